// File: rtl/superscalar_pkg.sv
//------------------------------------------------------------------------------
// superscalar_pkg : shared front-end types and constants for fetch/decode
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package superscalar_pkg;

  localparam int SEQ_W   = 16;
  localparam int INST_W  = 32;
  localparam int ISSUE_W = 2;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic [SEQ_W-1:0]  seq;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// fetch_fifo : circular fetch buffer, 3-wide enqueue, 0-3 dequeue, flush
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import superscalar_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           enq,
  input  logic [2:0][INST_W-1:0]         enqInst,
  input  logic [31:0]                    enqPc,
  input  logic [SEQ_W-1:0]               enqSeq,
  input  logic [$clog2(DEPTH):0]         deqCount,
  output logic [$clog2(DEPTH):0]         count,
  output logic [2:0]                     slotValid,
  output logic [2:0][INST_W-1:0]         slotInst,
  output logic [2:0][31:0]               slotPc,
  output logic [2:0][SEQ_W-1:0]          slotSeq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INST_W-1:0] r_inst [DEPTH];
  logic [31:0]       r_pc   [DEPTH];
  logic [SEQ_W-1:0]  r_seq  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_head <= r_head + PTR_W'(deqCount);
      if (enq) begin
        r_tail  <= r_tail + PTR_W'(3);
        r_count <= r_count - deqCount + (PTR_W+1)'(3);
      end else begin
        r_count <= r_count - deqCount;
      end
    end
  end

  // Payload needs no reset: every read is masked by the occupancy count.
  always_ff @(posedge clock) begin
    if (enq && !flush) begin
      for (int k = 0; k < 3; k++) begin
        r_inst[r_tail + PTR_W'(k)] <= enqInst[k];
        r_pc[r_tail + PTR_W'(k)]   <= enqPc + 32'(4 * k);
        r_seq[r_tail + PTR_W'(k)]  <= enqSeq + SEQ_W'(k);
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_slot
    logic [PTR_W-1:0] w_idx;
    assign w_idx        = r_head + PTR_W'(i);
    assign slotValid[i] = r_count > (PTR_W+1)'(i);
    assign slotInst[i]  = slotValid[i] ? r_inst[w_idx] : NOP_INST;
    assign slotPc[i]    = slotValid[i] ? r_pc[w_idx]   : 32'h0;
    assign slotSeq[i]   = slotValid[i] ? r_seq[w_idx]  : '0;
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_bundle_unit.sv
//------------------------------------------------------------------------------
// fetch_bundle_unit : fetches instruction triples and presents 3 decode slots
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_bundle_unit
  import superscalar_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          SEQ_W    = superscalar_pkg::SEQ_W
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata0,
  input  logic [31:0]        imem_rdata1,
  input  logic [31:0]        imem_rdata2,
  output logic [31:0]        alpha_inst,
  output logic [31:0]        beta_inst,
  output logic [31:0]        gamma_inst,
  output logic [31:0]        alpha_pc,
  output logic [31:0]        beta_pc,
  output logic [31:0]        gamma_pc,
  output logic [SEQ_W-1:0]   alpha_seq_num,
  output logic [SEQ_W-1:0]   beta_seq_num,
  output logic [SEQ_W-1:0]   gamma_seq_num,
  output logic               alpha_valid,
  output logic               beta_valid,
  output logic               gamma_valid,
  input  logic [ISSUE_W-1:0] issue_count,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      r_fetchPc;
  logic [31:0]      r_reqAddr;
  logic             r_epoch;
  logic             r_reqEpoch;
  logic             r_inflight;
  logic [SEQ_W-1:0] r_seqCtr;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_eff;
  logic [CNT_W-1:0] w_space;
  logic [CNT_W-1:0] w_need;
  logic             w_enq;

  logic [2:0]              w_slotValid;
  logic [2:0][INST_W-1:0]  w_slotInst;
  logic [2:0][31:0]        w_slotPc;
  logic [2:0][SEQ_W-1:0]   w_slotSeq;

  // Decode over-issue is clamped to what is actually buffered.
  always_comb begin
    w_eff = '0;
    if (!redirect_valid) begin
      w_eff = (CNT_W'(issue_count) > w_count) ? w_count : CNT_W'(issue_count);
    end
  end

  // Space after this cycle's dequeue must also cover a triple still in flight.
  assign w_space   = CNT_W'(DEPTH) - w_count + w_eff;
  assign w_need    = r_inflight ? CNT_W'(6) : CNT_W'(3);
  assign imem_req  = reset && !redirect_valid && (w_space >= w_need);
  assign imem_addr = r_fetchPc;

  assign w_enq = r_inflight && imem_rvalid && (r_reqEpoch == r_epoch) && !redirect_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetchPc  <= RESET_PC;
      r_reqAddr  <= '0;
      r_epoch    <= 1'b0;
      r_reqEpoch <= 1'b0;
      r_inflight <= 1'b0;
      r_seqCtr   <= '0;
    end else begin
      r_inflight <= imem_req;
      if (redirect_valid) begin
        r_fetchPc <= redirect_pc & ~32'h3;
        r_epoch   <= ~r_epoch;
      end else if (imem_req) begin
        r_fetchPc  <= r_fetchPc + 32'd12;
        r_reqAddr  <= r_fetchPc;
        r_reqEpoch <= r_epoch;
      end
      if (w_enq) begin
        r_seqCtr <= r_seqCtr + SEQ_W'(3);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .enq       (w_enq),
    .enqInst   ({imem_rdata2, imem_rdata1, imem_rdata0}),
    .enqPc     (r_reqAddr),
    .enqSeq    (r_seqCtr),
    .deqCount  (w_eff),
    .count     (w_count),
    .slotValid (w_slotValid),
    .slotInst  (w_slotInst),
    .slotPc    (w_slotPc),
    .slotSeq   (w_slotSeq)
  );

  assign alpha_valid   = w_slotValid[0];
  assign beta_valid    = w_slotValid[1];
  assign gamma_valid   = w_slotValid[2];
  assign alpha_inst    = w_slotInst[0];
  assign beta_inst     = w_slotInst[1];
  assign gamma_inst    = w_slotInst[2];
  assign alpha_pc      = w_slotPc[0];
  assign beta_pc       = w_slotPc[1];
  assign gamma_pc      = w_slotPc[2];
  assign alpha_seq_num = w_slotSeq[0];
  assign beta_seq_num  = w_slotSeq[1];
  assign gamma_seq_num = w_slotSeq[2];

  a_issueWithinCount: assert property (@(posedge clock) disable iff (!reset)
    redirect_valid || (CNT_W'(issue_count) <= w_count));

endmodule

`default_nettype wire

// File: tb/tb_fetch_bundle_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_bundle_unit : randomized bench with a queue-based fetch model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_bundle_unit;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] rd [3];
  logic [1:0]  issue_count;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] aInst, bInst, gInst, aPc, bPc, gPc;
  logic [15:0] aSeq, bSeq, gSeq;
  logic        aValid, bValid, gValid;

  always #5 clock = ~clock;

  fetch_bundle_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0), .SEQ_W(16)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata0(rd[0]), .imem_rdata1(rd[1]), .imem_rdata2(rd[2]),
    .alpha_inst(aInst), .beta_inst(bInst), .gamma_inst(gInst),
    .alpha_pc(aPc), .beta_pc(bPc), .gamma_pc(gPc),
    .alpha_seq_num(aSeq), .beta_seq_num(bSeq), .gamma_seq_num(gSeq),
    .alpha_valid(aValid), .beta_valid(bValid), .gamma_valid(gValid),
    .issue_count(issue_count), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  logic [31:0] dInst [3];
  logic [31:0] dPc   [3];
  logic [15:0] dSeq  [3];
  logic        dValid[3];
  assign dInst[0] = aInst;  assign dInst[1] = bInst;  assign dInst[2] = gInst;
  assign dPc[0]   = aPc;    assign dPc[1]   = bPc;    assign dPc[2]   = gPc;
  assign dSeq[0]  = aSeq;   assign dSeq[1]  = bSeq;   assign dSeq[2]  = gSeq;
  assign dValid[0] = aValid; assign dValid[1] = bValid; assign dValid[2] = gValid;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [15:0] seq;
  } ent_t;

  // Reference model: ordered queue of buffered instructions plus fetch state.
  ent_t        mq[$];
  logic [31:0] mFetchPc;
  logic [15:0] mSeq;
  bit          mPending;
  logic [31:0] mPendAddr;

  // Instruction memory responder state.
  bit          respPend;
  logic [31:0] respAddr;
  bit          spurious;
  bit          lastReq;
  logic [31:0] lastAddr;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int maxIssue();
    return (mq.size() < 3) ? mq.size() : 3;
  endfunction

  task automatic resetModel();
    mq.delete();
    mFetchPc  = 32'h0;
    mSeq      = 16'h0;
    mPending  = 1'b0;
    mPendAddr = 32'h0;
    respPend  = 1'b0;
    respAddr  = 32'h0;
  endtask

  // One clock cycle: drive, compare every output with the model, advance the model.
  task automatic step(input int issue, input bit redir, input logic [31:0] rpc);
    int   eff;
    bit   expReq;
    bit   respThis;
    bit   v;
    ent_t e;
    issue_count    = 2'(issue);
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (respPend) begin
      imem_rvalid = 1'b1;
      for (int k = 0; k < 3; k++) rd[k] = memWord(respAddr + 32'(4 * k));
    end else if (spurious && ($urandom_range(0, 7) == 0)) begin
      imem_rvalid = 1'b1;
      for (int k = 0; k < 3; k++) rd[k] = $urandom;
    end else begin
      imem_rvalid = 1'b0;
    end
    #1;
    eff    = redir ? 0 : issue;
    expReq = !redir && ((DEPTH - mq.size() + eff) >= (3 + 3 * int'(mPending)));
    for (int i = 0; i < 3; i++) begin
      v = (i < mq.size());
      if (v) e = mq[i];
      else begin e.inst = 32'h0; e.pc = 32'h0; e.seq = 16'h0; end
      checks++;
      if (dValid[i] !== v) begin errors++; $display("FAIL slot%0d_valid: got %0b expected %0b", i, dValid[i], v); end
      checks++;
      if (dInst[i] !== e.inst) begin errors++; $display("FAIL slot%0d_inst: got %h expected %h", i, dInst[i], e.inst); end
      checks++;
      if (dPc[i] !== e.pc) begin errors++; $display("FAIL slot%0d_pc: got %h expected %h", i, dPc[i], e.pc); end
      checks++;
      if (dSeq[i] !== e.seq) begin errors++; $display("FAIL slot%0d_seq: got %0d expected %0d", i, dSeq[i], e.seq); end
    end
    checks++;
    if (imem_req !== expReq) begin errors++; $display("FAIL imem_req: got %0b expected %0b", imem_req, expReq); end
    if (expReq) begin
      checks++;
      if (imem_addr !== mFetchPc) begin errors++; $display("FAIL imem_addr: got %h expected %h", imem_addr, mFetchPc); end
    end
    lastReq  = imem_req;
    lastAddr = imem_addr;
    respPend = imem_req;
    respAddr = imem_addr;
    respThis = mPending && imem_rvalid && !redir;
    @(posedge clock);
    if (redir) begin
      mq.delete();
      mFetchPc = {rpc[31:2], 2'b00};
      mPending = 1'b0;
    end else begin
      for (int k = 0; k < eff; k++) void'(mq.pop_front());
      if (respThis) begin
        for (int k = 0; k < 3; k++) begin
          e.pc   = mPendAddr + 32'(4 * k);
          e.inst = memWord(e.pc);
          e.seq  = mSeq + 16'(k);
          mq.push_back(e);
        end
        mSeq = mSeq + 16'd3;
      end
      mPending = expReq;
      if (expReq) begin
        mPendAddr = mFetchPc;
        mFetchPc  = mFetchPc + 32'd12;
      end
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; issue_count = '0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; spurious = 1'b0;
    for (int k = 0; k < 3; k++) rd[k] = '0;
    resetModel();
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dValid[i], dInst[i], dPc[i], dSeq[i]} !== 81'h0)
        begin errors++; $display("FAIL reset_slot%0d: got v=%0b i=%h p=%h s=%0d expected all 0", i, dValid[i], dInst[i], dPc[i], dSeq[i]); end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_first_fetch();
    step(0, 0, 0);
    checks++;
    if (lastReq !== 1'b1 || lastAddr !== 32'h0)
      begin errors++; $display("FAIL first_req: got req=%0b addr=%h expected req=1 addr=0", lastReq, lastAddr); end
    step(0, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dValid[i] !== 1'b1 || dPc[i] !== 32'(4 * i) || dSeq[i] !== 16'(i))
        begin errors++; $display("FAIL first_slot%0d: got v=%0b pc=%h seq=%0d expected v=1 pc=%h seq=%0d", i, dValid[i], dPc[i], dSeq[i], 4 * i, i); end
    end
    step(1, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dValid[i] !== 1'b1 || dPc[i] !== 32'(4 * (i + 1)) || dSeq[i] !== 16'(i + 1))
        begin errors++; $display("FAIL partial_slot%0d: got v=%0b pc=%h seq=%0d expected v=1 pc=%h seq=%0d", i, dValid[i], dPc[i], dSeq[i], 4 * (i + 1), i + 1); end
    end
  endtask

  task automatic test_fill_stall();
    logic [31:0] held [3];
    repeat (8) step(0, 0, 0);
    for (int i = 0; i < 3; i++) held[i] = dPc[i];
    checks++;
    if (lastReq !== 1'b0) begin errors++; $display("FAIL stall_req: got %0b expected 0", lastReq); end
    repeat (3) step(0, 0, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dPc[i] !== held[i]) begin errors++; $display("FAIL stall_stable%0d: got %h expected %h", i, dPc[i], held[i]); end
    end
    step(3, 0, 0);
    checks++;
    if (lastReq !== 1'b1) begin errors++; $display("FAIL resume_req: got %0b expected 1", lastReq); end
  endtask

  task automatic test_redirect();
    logic [15:0] seqBefore;
    for (int n = 0; n < 10 && !lastReq; n++) step(maxIssue(), 0, 0);
    step(maxIssue(), 1, 32'h103);
    seqBefore = mSeq;
    step(0, 0, 0);
    checks++;
    if (lastReq !== 1'b1 || lastAddr !== 32'h100)
      begin errors++; $display("FAIL redirect_addr: got req=%0b addr=%h expected req=1 addr=100", lastReq, lastAddr); end
    #1;
    checks++;
    if (aValid !== 1'b0) begin errors++; $display("FAIL redirect_early: got valid %0b expected 0", aValid); end
    step(0, 0, 0);
    #1;
    checks++;
    if (aValid !== 1'b1 || aPc !== 32'h100 || aSeq !== seqBefore)
      begin errors++; $display("FAIL redirect_alpha: got v=%0b pc=%h seq=%0d expected v=1 pc=100 seq=%0d", aValid, aPc, aSeq, seqBefore); end
  endtask

  task automatic test_back_to_back();
    step(maxIssue(), 1, 32'h200);
    step(0, 1, 32'h306);
    step(0, 0, 0);
    step(0, 0, 0);
    #1;
    checks++;
    if (aValid !== 1'b1 || aPc !== 32'h304)
      begin errors++; $display("FAIL b2b_alpha: got v=%0b pc=%h expected v=1 pc=304", aValid, aPc); end
  endtask

  task automatic test_random(input int cycles);
    spurious = 1'b1;
    for (int n = 0; n < cycles; n++)
      step($urandom_range(0, maxIssue()), ($urandom_range(0, 15) == 0), $urandom);
    spurious = 1'b0;
  endtask

  task automatic test_reset_midop();
    test_random(25);
    reset = 1'b0; issue_count = '0; redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || aValid !== 1'b0 || aPc !== 32'h0)
      begin errors++; $display("FAIL midreset: got req=%0b v=%0b pc=%h expected 0", imem_req, aValid, aPc); end
    @(negedge clock);
    reset = 1'b1;
    resetModel();
    respPend = 1'b1;
    respAddr = 32'h40;
    repeat (4) step(0, 0, 0);
  endtask

  task automatic test_seq_wrap();
    bit found = 1'b0;
    step(maxIssue(), 1, 32'h1000);
    for (int n = 0; n < 25000 && !found; n++) begin
      if (mq.size() >= 3 && mq[0].seq == 16'hFFFF) found = 1'b1;
      else step(maxIssue(), 0, 0);
    end
    #1;
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_timeout: got no 65535 triple expected one"); end
    checks++;
    if (aSeq !== 16'hFFFF || bSeq !== 16'h0 || gSeq !== 16'h1 || !gValid)
      begin errors++; $display("FAIL wrap_seq: got %0d/%0d/%0d expected 65535/0/1", aSeq, bSeq, gSeq); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_first_fetch();
    test_fill_stall();
    test_redirect();
    test_back_to_back();
    test_random(3000);
    test_reset_midop();
    test_seq_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fetch_bundle_unit.md
Name: fetch_bundle_unit

Overview:
- Front-end producer for the 3-wide decode stage. It fetches sequential instruction triples from instruction memory into a circular fetch buffer.
- Each cycle it presents the three oldest buffered instructions as slots alpha/beta/gamma, each with PC and sequence number, to hazard detect/decode.
- It retires however many slots decode accepts, in order, and replays the rest the next cycle.
- It services branch redirects by flushing and refetching from the target.

Parameters:
- DEPTH, 8, fetch buffer entries; power of two, minimum 6.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- SEQ_W, 16, sequence number width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  32  word-aligned address of first word of triple
- imem_rvalid  in  1  response valid; fixed one cycle after imem_req
- imem_rdata0/1/2  in  32 each  words at imem_addr, +4, +8
- alpha_inst/beta_inst/gamma_inst  out  32 each  slot instruction
- alpha_pc/beta_pc/gamma_pc  out  32 each  slot PC
- alpha_seq_num/beta_seq_num/gamma_seq_num  out  SEQ_W each  slot sequence number
- alpha_valid/beta_valid/gamma_valid  out  1 each  slot holds a real instruction
- issue_count  in  2  slots accepted by decode this cycle (0-3), oldest first
- redirect_valid  in  1  branch/jump redirect
- redirect_pc  in  32  redirect target; bits [1:0] ignored, forced 00

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; buffer empty; seq counter=0; in-flight=0; epoch=0.
  - All slot outputs are 0; valids are 0; imem_req=0.
- Slots are combinational views of buffer entries head, head+1, head+2 (mod DEPTH).
  - slot valid = entry index < count.
  - An invalid slot drives inst=32'h0000_0000 (nop), pc=0, seq=0.
- Issue:
  - eff = min(issue_count, count); head+=eff; count-=eff at clock edge.
  - issue_count greater than count is a decode error: clamp to count, and a simulation assertion fires.
  - Unaccepted slots re-present next cycle with identical inst/pc/seq (replay).
- Request rule:
  - imem_req=1 when no redirect this cycle and (DEPTH - count + eff) >= 3 + 3*inflight.
  - On request: imem_addr=fetch_pc; fetch_pc+=12 at edge; inflight=1; the request is tagged with the current epoch.
- Response, the cycle after a request:
  - If imem_rvalid and tag==epoch, enqueue the three words at tail with pc=addr, addr+4, addr+8 and seq=s, s+1, s+2. The seq counter advances by 3. Sequence numbers wrap modulo 2^SEQ_W (65535 -> 0).
  - Enqueue and dequeue in the same cycle both apply: count_next = count - eff + 3.
  - A stale tag (epoch mismatch) discards the words; no enqueue, no seq advance.
  - inflight clears in either case.
  - imem_rvalid with no outstanding request is ignored.
- Redirect (redirect_valid=1), applied at the edge:
  - Buffer flushed: count=0, head=tail.
  - fetch_pc={redirect_pc[31:2],2'b00}; epoch toggles; issue_count that cycle is ignored.
  - An in-flight response arriving next cycle is dropped as stale.
  - imem_req is 0 in the redirect cycle; fetching resumes the following cycle.
  - Seq counter is NOT reset; numbering continues monotonically across redirects.
  - Back-to-back redirects: the last one wins.
- Throughput: steady state with issue_count=3 every cycle sustains one triple per cycle once primed.
  - Latency from redirect to first valid alpha slot is 3 cycles: redirect edge, request, response enqueue, then visible.
- fetch_pc wraps modulo 2^32 with no special handling.
- Reset asserted mid-operation aborts everything; a late imem_rvalid after release is ignored because inflight=0.

Decomposition:
- Shared package superscalar_pkg:
  - SEQ_W and INST_W constants; NOP_INST constant (32'h0).
  - Fetch entry typedef {inst[31:0], pc[31:0], seq[SEQ_W-1:0]}.
  - Issue-count width constant, reused by hazard detect/decode.
- One sub-module, fetch_fifo: DEPTH-entry circular buffer with 3-wide enqueue, 0-3 dequeue, flush, and head/head+1/head+2 read ports.
- Request/epoch/seq control stays in fetch_bundle_unit.

Test Plan:
- Reset -> all outputs 0, valids 0, imem_req 0. First request after release has addr 0x0. Next cycle, with rvalid, slots read pc 0x0/0x4/0x8 and seq 0/1/2.
- Straight-line fetch, issue_count=3 every cycle -> imem_req every cycle after priming; seq increments by 3 per cycle; no bubbles.
- Partial issue: issue_count=1 with slots pc 0x0/0x4/0x8 -> next cycle alpha=0x4 seq 1, beta=0x8 seq 2, gamma=0xC seq 3.
- issue_count=0 repeatedly -> buffer fills to 6 and imem_req drops to 0. Contents stay stable; resuming issue_count=3 re-asserts imem_req.
- Redirect to 0x103 while a request is in flight -> stale response discarded, next imem_addr=0x100. First valid alpha 3 cycles later at pc 0x100 with seq continuing from pre-redirect value.
- Seq counter preset near wrap (65534) -> triple seq 65534, 65535, 0.
